// File: rtl/operand_sweep_gen.sv
// operand_sweep_gen: NCH x WIDTH operand generator with binary, per-channel step, Gray and hold sweeps.
// Optional macro OPGEN_PAUSE_EN adds a pause input that freezes the sweep while in RUN.
module operand_sweep_gen #(
  parameter int  WIDTH = 8,
  parameter int  NCH   = 4,
  localparam int TOTAL = NCH * WIDTH
) (
  input  logic             clk,
  input  logic             reset,
`ifdef OPGEN_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [TOTAL-1:0] seed,
  input  logic [31:0]      len,
  output logic [TOTAL-1:0] ops,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             wrapped,
  output logic [31:0]      iter_cnt
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [1:0] M_BIN  = 2'd0;
  localparam logic [1:0] M_STEP = 2'd1;
  localparam logic [1:0] M_GRAY = 2'd2;
  localparam logic [1:0] M_HOLD = 2'd3;

  state_t           state_q, state_d;
  logic [TOTAL-1:0] bin_q, bin_d;
  logic [TOTAL-1:0] ops_q, ops_d;
  logic [TOTAL-1:0] seed_q, seed_d;
  logic [1:0]       mode_q, mode_d;
  logic [31:0]      len_q, len_d;
  logic [31:0]      iter_q, iter_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrapped_q, wrapped_d;

  logic [TOTAL-1:0] step_bin;
  logic [TOTAL-1:0] next_bin;
  logic [31:0]      iter_inc;
  logic             term_len, term_wrap, pause_w;

`ifdef OPGEN_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  function automatic logic [TOTAL-1:0] map_ops(input logic [1:0] m, input logic [TOTAL-1:0] b);
    map_ops = (m == M_GRAY) ? (b ^ (b >> 1)) : b;
  endfunction

  // Step mode: every channel carries independently, so no cross-channel carry.
  genvar gi;
  for (gi = 0; gi < NCH; gi++) begin : g_step
    assign step_bin[gi*WIDTH +: WIDTH] = bin_q[gi*WIDTH +: WIDTH] + WIDTH'(gi + 1);
  end

  always_comb begin
    case (mode_q)
      M_BIN, M_GRAY: next_bin = bin_q + TOTAL'(1);
      M_STEP:        next_bin = step_bin;
      default:       next_bin = bin_q;
    endcase
  end

  assign term_len  = (len_q != 32'd0) && (iter_q == len_q);
  assign term_wrap = (mode_q != M_HOLD) && (next_bin == seed_q);
  assign iter_inc  = (iter_q == 32'hFFFF_FFFF) ? iter_q : iter_q + 32'd1;

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    ops_d     = ops_q;
    seed_d    = seed_q;
    mode_d    = mode_q;
    len_d     = len_q;
    iter_d    = iter_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wrapped_d = wrapped_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d   = S_RUN;
          bin_d     = seed;
          ops_d     = map_ops(mode, seed);
          seed_d    = seed;
          mode_d    = mode;
          len_d     = len;
          iter_d    = 32'd1;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          wrapped_d = 1'b0;
        end
      end
      S_RUN: begin
        // stop always wins; the other exits are suspended while paused
        if (stop || (!pause_w && (term_len || term_wrap))) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (!pause_w && term_wrap) wrapped_d = 1'b1;
        end else if (!pause_w) begin
          bin_d   = next_bin;
          ops_d   = map_ops(mode_q, next_bin);
          iter_d  = iter_inc;
          valid_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bin_q     <= '0;
      ops_q     <= '0;
      seed_q    <= '0;
      mode_q    <= '0;
      len_q     <= '0;
      iter_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      ops_q     <= ops_d;
      seed_q    <= seed_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      iter_q    <= iter_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign ops      = ops_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wrapped  = wrapped_q;
  assign iter_cnt = iter_q;

endmodule

// File: tb/tb_operand_sweep_gen.sv
// Bench for operand_sweep_gen (WIDTH=4, NCH=2): directed scenarios plus randomized runs vs a sequence model.
module tb_operand_sweep_gen;
  localparam int WIDTH = 4;
  localparam int NCH   = 2;
  localparam int TOTAL = WIDTH * NCH;

  logic             clk = 1'b0;
  logic             reset, start, stop;
  logic [1:0]       mode;
  logic [TOTAL-1:0] seed;
  logic [31:0]      len;
  logic [TOTAL-1:0] ops;
  logic             valid, busy, done, wrapped;
  logic [31:0]      iter_cnt;
`ifdef OPGEN_PAUSE_EN
  logic             pause;
`endif

  always #5 clk = ~clk;

  operand_sweep_gen #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk(clk), .reset(reset),
`ifdef OPGEN_PAUSE_EN
    .pause(pause),
`endif
    .start(start), .stop(stop), .mode(mode), .seed(seed), .len(len),
    .ops(ops), .valid(valid), .busy(busy), .done(done), .wrapped(wrapped), .iter_cnt(iter_cnt)
  );

  int checks = 0;
  int passed = 0;

  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  int          exp_iter;
  bit          exp_wrap;
  int          done_cnt, gaps, last_valid_cyc, done_cyc;
  bit          timed_out;
  logic        first_valid, fin_wrap, fin_vb, done_after;
  logic [7:0]  first_ops, fin_ops;
  logic [31:0] fin_iter;

  // Reference: list of vectors a run emits, derived from the sweep rules with plain arithmetic.
  task automatic model_run(input logic [7:0] s, input logic [1:0] m, input int l, input int stop_after);
    int cur, nxt, n, s_i;
    exp_q.delete();
    exp_wrap = 0;
    s_i = int'(s);
    cur = s_i;
    n = 1;
    forever begin
      exp_q.push_back((m == 2'd2) ? 8'(cur ^ (cur >> 1)) : 8'(cur));
      case (m)
        2'd0, 2'd2: nxt = (cur + 1) % 256;
        2'd1:       nxt = (((cur / 16) + 2) % 16) * 16 + ((cur % 16) + 1) % 16;
        default:    nxt = cur;
      endcase
      if (m != 2'd3 && nxt == s_i) exp_wrap = 1;
      if ((l != 0 && n == l) || stop_after == n || exp_wrap) break;
      cur = nxt;
      n++;
    end
    exp_iter = n;
  endtask

  // Drives one run and records what the DUT emitted; all checking is done by the callers.
  task automatic run_collect(input logic [7:0] s, input logic [1:0] m, input logic [31:0] l,
                             input int stop_after, input int start_at, input int pause_at, input bit scramble);
    int pause_left;
    bit pause_used;
    got_q.delete();
    done_cnt = 0; gaps = 0; timed_out = 0; last_valid_cyc = -1; done_cyc = -1;
    pause_left = 0; pause_used = 0;
    @(negedge clk);
    start = 1; stop = 0; seed = s; mode = m; len = l;
    @(negedge clk);
    start = 0;
    if (scramble) begin
      mode = 2'($urandom);
      len  = 32'($urandom_range(1, 2));
    end
    first_valid = valid;
    first_ops   = ops;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        fin_iter = iter_cnt; fin_wrap = wrapped; fin_ops = ops; fin_vb = valid | busy;
        break;
      end
      if (valid) begin
        got_q.push_back(ops);
        last_valid_cyc = cyc;
      end else if (busy) begin
        gaps++;
      end
      stop  = valid && stop_after != 0 && iter_cnt == 32'(stop_after);
      start = valid && start_at != 0 && iter_cnt == 32'(start_at);
      if (pause_left > 0) begin
        pause_left--;
`ifdef OPGEN_PAUSE_EN
        if (pause_left == 0) pause = 0;
`endif
      end else if (!pause_used && valid && pause_at != 0 && iter_cnt == 32'(pause_at)) begin
        pause_left = 3;
        pause_used = 1;
`ifdef OPGEN_PAUSE_EN
        pause = 1;
`endif
      end
      @(negedge clk);
    end
    if (done_cnt == 0) timed_out = 1;
    start = 0; stop = 0;
`ifdef OPGEN_PAUSE_EN
    pause = 0;
`endif
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    bit seen;
    #3;
    checks++; if ({ops, valid, busy, done, wrapped, iter_cnt} !== '0) $display("FAIL reset_init: got ops=%h v=%b b=%b d=%b w=%b it=%0d need all 0", ops, valid, busy, done, wrapped, iter_cnt); else passed++;
    @(negedge clk); reset = 1;
    @(negedge clk); start = 1; seed = 8'h37; mode = 2'd0; len = 32'd0;
    @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    checks++; if (ops !== 8'h3B || valid !== 1'b1) $display("FAIL reset_prerun: got ops=%h v=%b need 3b 1", ops, valid); else passed++;
    #2 reset = 0;
    #1;
    checks++; if ({ops, valid, busy, done, wrapped, iter_cnt} !== '0) $display("FAIL reset_async: got ops=%h v=%b b=%b d=%b w=%b it=%0d need all 0", ops, valid, busy, done, wrapped, iter_cnt); else passed++;
    @(negedge clk); reset = 1;
    seen = 0;
    repeat (4) begin @(negedge clk); seen |= (done | busy | valid); end
    checks++; if (seen !== 1'b0) $display("FAIL reset_release: got activity=%b need 0", seen); else passed++;
    $display("test_reset done");
  endtask

  task automatic test_mode0_len3();
    logic [7:0] e [3];
    e = '{8'hFE, 8'hFF, 8'h00};
    run_collect(8'hFE, 2'd0, 32'd3, 0, 0, 0, 0);
    checks++; if (timed_out || got_q.size() != 3) $display("FAIL m0_len3_count: got %0d timeout=%b need 3", got_q.size(), timed_out); else passed++;
    checks++; if (first_valid !== 1'b1 || first_ops !== 8'hFE) $display("FAIL m0_len3_latency: got v=%b ops=%h need 1 fe", first_valid, first_ops); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== e[i]) $display("FAIL m0_len3_vec%0d: got %h need %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, e[i]); else passed++;
    end
    checks++; if (fin_iter !== 32'd3 || fin_wrap !== 1'b0 || fin_ops !== 8'h00) $display("FAIL m0_len3_final: got it=%0d w=%b ops=%h need 3 0 00", fin_iter, fin_wrap, fin_ops); else passed++;
    checks++; if (done_cyc != last_valid_cyc + 1 || fin_vb !== 1'b0 || done_after !== 1'b0) $display("FAIL m0_len3_done: got dcyc=%0d lcyc=%0d vb=%b after=%b need lcyc+1 0 0", done_cyc, last_valid_cyc, fin_vb, done_after); else passed++;
    $display("test_mode0_len3: %0d vectors, iter=%0d", got_q.size(), fin_iter);
  endtask

  task automatic test_mode0_wrap();
    int bad;
    run_collect(8'h00, 2'd0, 32'd0, 0, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 8'(i)) bad++;
    checks++; if (timed_out || got_q.size() != 256 || bad != 0) $display("FAIL m0_wrap_seq: got count=%0d bad=%0d need 256 0", got_q.size(), bad); else passed++;
    checks++; if (fin_iter !== 32'd256 || fin_wrap !== 1'b1) $display("FAIL m0_wrap_final: got it=%0d w=%b need 256 1", fin_iter, fin_wrap); else passed++;
    checks++; if (done_cyc != last_valid_cyc + 1 || done_after !== 1'b0) $display("FAIL m0_wrap_done: got dcyc=%0d lcyc=%0d after=%b", done_cyc, last_valid_cyc, done_after); else passed++;
    $display("test_mode0_wrap: %0d vectors, wrapped=%b", got_q.size(), fin_wrap);
  endtask

  task automatic test_mode1_step();
    logic [7:0] e [4];
    e = '{8'h00, 8'h21, 8'h42, 8'h63};
    run_collect(8'h00, 2'd1, 32'd4, 0, 0, 0, 1);
    checks++; if (timed_out || got_q.size() != 4) $display("FAIL m1_count: got %0d need 4", got_q.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== e[i]) $display("FAIL m1_vec%0d: got %h need %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, e[i]); else passed++;
    end
    $display("test_mode1_step: %0d vectors", got_q.size());
  endtask

  task automatic test_mode2_gray();
    logic [7:0] e [5];
    e = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06};
    run_collect(8'h00, 2'd2, 32'd5, 0, 0, 0, 0);
    checks++; if (timed_out || got_q.size() != 5) $display("FAIL m2_count: got %0d need 5", got_q.size()); else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== e[i]) $display("FAIL m2_vec%0d: got %h need %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, e[i]); else passed++;
    end
    $display("test_mode2_gray: %0d vectors", got_q.size());
  endtask

  task automatic test_mode3_stop();
    int bad;
    run_collect(8'hA5, 2'd3, 32'd0, 10, 4, 0, 0);
    bad = 0;
    foreach (got_q[i]) if (got_q[i] !== 8'hA5) bad++;
    checks++; if (timed_out || got_q.size() != 10 || bad != 0) $display("FAIL m3_seq: got count=%0d bad=%0d need 10 0", got_q.size(), bad); else passed++;
    checks++; if (fin_iter !== 32'd10 || fin_ops !== 8'hA5 || fin_wrap !== 1'b0) $display("FAIL m3_final: got it=%0d ops=%h w=%b need 10 a5 0", fin_iter, fin_ops, fin_wrap); else passed++;
    checks++; if (done_cnt != 1 || done_after !== 1'b0 || gaps != 0) $display("FAIL m3_done: got dcnt=%0d after=%b gaps=%0d need 1 0 0", done_cnt, done_after, gaps); else passed++;
    $display("test_mode3_stop: %0d vectors, iter=%0d", got_q.size(), fin_iter);
  endtask

  task automatic test_start_stop_together();
    @(negedge clk); start = 1; stop = 1; seed = 8'h10; mode = 2'd0; len = 32'd2;
    @(negedge clk); start = 0; stop = 0;
    checks++; if (valid !== 1'b1 || ops !== 8'h10) $display("FAIL ss_first: got v=%b ops=%h need 1 10", valid, ops); else passed++;
    @(negedge clk);
    checks++; if (valid !== 1'b1 || ops !== 8'h11) $display("FAIL ss_second: got v=%b ops=%h need 1 11", valid, ops); else passed++;
    @(negedge clk);
    checks++; if (done !== 1'b1 || iter_cnt !== 32'd2) $display("FAIL ss_done: got d=%b it=%0d need 1 2", done, iter_cnt); else passed++;
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL ss_idle: got d=%b b=%b need 0 0", done, busy); else passed++;
    $display("test_start_stop_together done");
  endtask

`ifdef OPGEN_PAUSE_EN
  task automatic test_pause();
    int bad;
    run_collect(8'h40, 2'd0, 32'd8, 0, 0, 3, 0);
    bad = 0;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 8'(8'h40 + i)) bad++;
    checks++; if (timed_out || got_q.size() != 8 || bad != 0) $display("FAIL pause_seq: got count=%0d bad=%0d need 8 0", got_q.size(), bad); else passed++;
    checks++; if (gaps != 3 || fin_iter !== 32'd8) $display("FAIL pause_gap: got gaps=%0d it=%0d need 3 8", gaps, fin_iter); else passed++;
    $display("test_pause: %0d vectors, gaps=%0d", got_q.size(), gaps);
  endtask
`endif

  task automatic test_random();
    logic [7:0] s;
    logic [1:0] m;
    int l, sa, bad;
    bit scr;
    for (int r = 0; r < 12; r++) begin
      s   = 8'($urandom);
      m   = 2'($urandom);
      l   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
      sa  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 40));
      scr = 1'($urandom);
      if (m == 2'd3 && l == 0 && sa == 0) sa = 7;
      model_run(s, m, l, sa);
      run_collect(s, m, 32'(l), sa, 0, 0, scr);
      bad = 0;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
      checks++; if (timed_out || got_q.size() != exp_q.size() || bad != 0) $display("FAIL rand%0d_seq: got count=%0d bad=%0d need %0d 0", r, got_q.size(), bad, exp_q.size()); else passed++;
      checks++; if (fin_iter !== 32'(exp_iter) || fin_wrap !== exp_wrap) $display("FAIL rand%0d_final: got it=%0d w=%b need %0d %b", r, fin_iter, fin_wrap, exp_iter, exp_wrap); else passed++;
      checks++; if (done_cnt != 1 || done_after !== 1'b0 || gaps != 0) $display("FAIL rand%0d_done: got dcnt=%0d after=%b gaps=%0d need 1 0 0", r, done_cnt, done_after, gaps); else passed++;
      $display("rand%0d: seed=%h mode=%0d len=%0d stop_at=%0d vectors=%0d iter=%0d wrapped=%b", r, s, m, l, sa, got_q.size(), fin_iter, fin_wrap);
    end
  endtask

  initial begin
    reset = 1; start = 0; stop = 0; mode = 2'd0; seed = '0; len = '0;
`ifdef OPGEN_PAUSE_EN
    pause = 0;
`endif
    #1 reset = 0;
    test_reset();
    test_mode0_len3();
    test_mode0_wrap();
    test_mode1_step();
    test_mode2_gray();
    test_mode3_stop();
    test_start_stop_together();
`ifdef OPGEN_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
